imem_responder: RTL and testbench

//   Responder side of the core's instruction-fetch interface: accepts a fetch

---
 rtl/imem_responder.sv | 138 +++++++++++++
 tb/tb_imem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Responder side of the core's instruction-fetch interface. One fetch is
//   outstanding at most. A request is accepted in IDLE. The 32-bit word is
//   returned LATENCY cycles after the accept edge and held until the core
//   takes it. The backing array is word-addressed. It is filled through the
//   preload port, which is accepted in any state.
//
// Ports
//   clk        in   1   clock, all logic on rising edge
//   rst        in   1   synchronous active-high reset
//   req_valid  in   1   core presents a fetch address
//   req_ready  out  1   responder can accept a request (state == IDLE)
//   req_addr   in   32  byte address of the instruction
//   rsp_valid  out  1   rsp_inst / rsp_err are valid
//   rsp_ready  in   1   core accepts the response
//   rsp_inst   out  32  instruction word (0 on error or when not valid)
//   rsp_err    out  1   address misaligned or outside the array
//   load_en    in   1   preload write strobe
//   load_addr  in   32  preload byte address (same mapping as req_addr)
//   load_data  in   32  preload word
//   busy       out  1   state != IDLE
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // A mapped address is word aligned, at or above the base (no wrap), and
    // its word offset falls inside the array.
    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        // NOTE: locals inside functions and combinational code use blocking
        // assignments; only clocked state uses non-blocking.
        off = addr - BASE_ADDR;
        return (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
               ((off >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    logic [31:0]      mem [DEPTH_WORDS];
    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [31:0]      addr_q;
    logic [31:0]      fetch_addr;
    logic             fetch_ok;
    logic [IDX_W-1:0] fetch_idx;
    logic             enter_resp;

    // With LATENCY == 1 the RESP-entry edge is the accept edge itself, so the
    // array is read with the live request address rather than the latched one.
    assign fetch_addr = (state == S_IDLE) ? req_addr : addr_q;
    assign fetch_ok   = addr_ok(fetch_addr);
    assign fetch_idx  = addr_idx(fetch_addr);
    assign enter_resp = ((state == S_IDLE) && req_valid && (LATENCY == 1)) ||
                        ((state == S_WAIT) && (cnt == 4'd1));

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    // NOTE: the array has no reset. Its contents survive rst, and a reset
    // port on a RAM would prevent mapping it onto block memory.
    always_ff @(posedge clk) begin
        if (load_en && addr_ok(load_addr)) begin
            mem[addr_idx(load_addr)] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            addr_q   <= 32'd0;
            rsp_inst <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= 4'(LATENCY - 1);
                        state  <= (LATENCY > 1) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Clearing the payload on handshake keeps it 0 whenever
                    // rsp_valid is low.
                    if (rsp_ready) begin
                        state    <= S_IDLE;
                        rsp_inst <= 32'd0;
                        rsp_err  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The read sees the array before any same-edge preload write.
            if (enter_resp) begin
                rsp_err  <= !fetch_ok;
                rsp_inst <= fetch_ok ? mem[fetch_idx] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          NI    = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NI-1:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0]     req_addr, load_addr, load_data;
    logic            load_en;
    logic [31:0]     rsp_inst [NI];

    int              tests_run    = 0;
    int              tests_failed = 0;
    int              cycle        = 0;
    int              last_accept  = 0;
    logic [31:0]     model_mem [DEPTH];
    rsp_t            sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_responder #(
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (BASE),
            .LATENCY    (lat_of(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_inst (rsp_inst[g]),
            .rsp_err  (rsp_err[g]),
            .load_en  (load_en),
            .load_addr(load_addr),
            .load_data(load_data),
            .busy     (busy[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit in_map(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
    endfunction

    function automatic rsp_t expect_of(input logic [31:0] a);
        rsp_t r;
        if (in_map(a)) begin
            r.inst = model_mem[int'((a - BASE) >> 2)];
            r.err  = 1'b0;
        end else begin
            r.inst = 32'd0;
            r.err  = 1'b1;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
        if (in_map(a)) model_mem[int'((a - BASE) >> 2)] = d;
    endtask

    // One fetch on instance d: expected response pushed at accept, compared on
    // rsp_valid. Optionally stalls rsp_ready and injects a preload of the same
    // word load_k cycles after the accept edge.
    task automatic fetch(input int d, input logic [31:0] a, input rsp_t exp,
                         input int stall, input int load_k, input logic [31:0] load_val);
        int          cyc;
        rsp_t        r;
        logic [31:0] held_inst;
        logic        held_err;
        req_addr     = a;
        req_valid[d] = 1'b1;
        tests_run++;
        if (req_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL req_ready_idle[%0d]: got %b want 1", d, req_ready[d]);
        end
        last_accept = cycle;
        sb.push_back(exp);
        step();
        req_valid[d] = 1'b0;
        cyc = 1;
        while (1) begin
            load_en = (cyc == load_k);
            if (load_en) begin
                load_addr = a;
                load_data = load_val;
            end
            if (rsp_valid[d] === 1'b1 || cyc > 40) break;
            step();
            cyc++;
        end
        load_en = 1'b0;
        tests_run++;
        if (cyc !== lat_of(d)) begin
            tests_failed++;
            $display("FAIL latency[%0d] addr %h: got %0d cycles want %0d", d, a, cyc, lat_of(d));
        end
        tests_run++;
        if (req_ready[d] !== 1'b0 || busy[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL resp_state[%0d]: req_ready %b busy %b want 0 1", d, req_ready[d], busy[d]);
        end
        held_inst = rsp_inst[d];
        held_err  = rsp_err[d];
        for (int s = 0; s < stall; s++) begin
            step();
            tests_run++;
            if (rsp_valid[d] !== 1'b1 || rsp_inst[d] !== held_inst ||
                rsp_err[d] !== held_err || req_ready[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall[%0d] cyc %0d: valid %b inst %h err %b rdy %b want 1 %h %b 0",
                         d, s, rsp_valid[d], rsp_inst[d], rsp_err[d], req_ready[d], held_inst, held_err);
            end
        end
        r = sb.pop_front();
        tests_run++;
        if (rsp_inst[d] !== r.inst || rsp_err[d] !== r.err) begin
            tests_failed++;
            $display("FAIL data[%0d] addr %h: got inst %h err %b want inst %h err %b",
                     d, a, rsp_inst[d], rsp_err[d], r.inst, r.err);
        end
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
        tests_run++;
        if (rsp_valid[d] !== 1'b0 || rsp_inst[d] !== 32'd0 || rsp_err[d] !== 1'b0 ||
            req_ready[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_handshake[%0d]: valid %b inst %h err %b rdy %b want 0 0 0 1",
                     d, rsp_valid[d], rsp_inst[d], rsp_err[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        tests_run++;
        if (req_ready !== 3'b111 || rsp_valid !== 3'b000 || busy !== 3'b000 || rsp_err !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: rdy %b valid %b busy %b err %b want 111 000 000 000",
                     req_ready, rsp_valid, busy, rsp_err);
        end
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (rsp_inst[i] !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_inst[%0d]: got %h want 0", i, rsp_inst[i]);
            end
        end
    endtask

    task automatic test_basic();
        load(BASE, 32'h0000_0413);
        fetch(0, BASE, expect_of(BASE), 0, 0, 32'd0);
        fetch(1, BASE, expect_of(BASE), 0, 0, 32'd0);
    endtask

    task automatic test_stall();
        load(BASE + 32'h10, 32'hCAFE_0001);
        fetch(2, BASE + 32'h10, expect_of(BASE + 32'h10), 3, 0, 32'd0);
    endtask

    task automatic test_errors();
        logic [31:0] last;
        last = BASE + 32'(4 * (DEPTH - 1));
        load(last, 32'h1234_5678);
        // Dropped preloads: out of range (would alias word 0 if wrapped) and misaligned.
        load(BASE + 32'(4 * DEPTH), 32'hBAD0_BAD0);
        load(BASE + 32'h1, 32'hBAD1_BAD1);
        fetch(0, BASE + 32'h2, expect_of(BASE + 32'h2), 0, 0, 32'd0);
        fetch(0, 32'h7FFF_FFFC, expect_of(32'h7FFF_FFFC), 0, 0, 32'd0);
        fetch(2, BASE + 32'(4 * DEPTH), expect_of(BASE + 32'(4 * DEPTH)), 1, 0, 32'd0);
        fetch(0, 32'hFFFF_FFFC, expect_of(32'hFFFF_FFFC), 0, 0, 32'd0);
        fetch(0, last, expect_of(last), 0, 0, 32'd0);
        fetch(0, BASE, expect_of(BASE), 0, 0, 32'd0);
    endtask

    task automatic test_load_during_wait();
        rsp_t e;
        load(BASE + 32'h40, 32'h1111_1111);
        load(BASE + 32'h44, 32'h2222_2222);
        // Load lands one edge after accept, before RESP entry: new data.
        e.inst = 32'hDEAD_BEEF;
        e.err  = 1'b0;
        fetch(1, BASE + 32'h40, e, 0, 1, 32'hDEAD_BEEF);
        model_mem[16] = 32'hDEAD_BEEF;
        // Load lands on the RESP-entry edge: old data.
        e.inst = 32'h2222_2222;
        fetch(1, BASE + 32'h44, e, 0, 2, 32'hDEAD_BEEF);
        model_mem[17] = 32'hDEAD_BEEF;
        fetch(1, BASE + 32'h44, expect_of(BASE + 32'h44), 0, 0, 32'd0);
    endtask

    task automatic test_reset_mid();
        bit rose;
        load(BASE + 32'h80, 32'h5555_AAAA);
        req_addr     = BASE + 32'h80;
        req_valid[2] = 1'b1;
        step();
        req_valid[2] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (req_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_idle: rdy %b busy %b want 1 0", req_ready[2], busy[2]);
        end
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[2] !== 1'b0) rose = 1'b1;
            step();
        end
        tests_run++;
        if (rose) begin
            tests_failed++;
            $display("FAIL reset_mid_drop: got rsp_valid 1 want 0");
        end
        fetch(2, BASE + 32'h80, expect_of(BASE + 32'h80), 0, 0, 32'd0);
    endtask

    task automatic test_back_to_back(input int d);
        int prev;
        for (int i = 0; i < 8; i++) load(BASE + 32'(32'h200 + 4 * i), 32'hA5A5_0000 ^ $urandom);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = BASE + 32'(32'h200 + 4 * i);
            prev = last_accept;
            fetch(d, a, expect_of(a), 0, 0, 32'd0);
            if (i > 0) begin
                tests_run++;
                if (last_accept - prev !== lat_of(d) + 1) begin
                    tests_failed++;
                    $display("FAIL b2b_period[%0d] #%0d: got %0d cycles want %0d",
                             d, i, last_accept - prev, lat_of(d) + 1);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_addr  = 32'd0;
        load_en   = 1'b0;
        load_addr = 32'd0;
        load_data = 32'd0;
        test_reset();
        test_basic();
        test_stall();
        test_errors();
        test_load_during_wait();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(2);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
